// File: rtl/core_clint.sv
// core_clint: multi-hart machine timer and software interrupt unit with
// a tick prescaler and byte-strobed MMIO access.
module core_clint #(
  parameter int          NHARTS         = 2,
  parameter logic [63:0] MMIO_BASE_ADDR = 64'h0000_0000_0000_1000,
  parameter logic [63:0] MMIO_BASE_MASK = 64'h0000_0000_0000_1FFF,
  parameter logic [63:0] MTIMECMP_RESET = 64'hFFFF_FFFF_FFFF_FFFF,
  parameter int          TICK_DIV       = 1
) (
  input  logic              g_clk,
  input  logic              g_resetn,
  input  logic              inhibit_tm,
  input  logic              mmio_req,
  input  logic              mmio_wen,
  input  logic [7:0]        mmio_strb,
  input  logic [63:0]       mmio_addr,
  input  logic [63:0]       mmio_wdata,
  output logic              mmio_gnt,
  output logic [63:0]       mmio_rdata,
  output logic              mmio_error,
  output logic [63:0]       ctr_time,
  output logic [NHARTS-1:0] timer_interrupt,
  output logic [NHARTS-1:0] soft_interrupt
);
  localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(TICK_DIV - 1);
  logic [63:0]       r_mtime;
  logic [PW-1:0]     r_pre;
  logic [63:0]       r_cmp [NHARTS];
  logic [NHARTS-1:0] r_msip;
  logic [NHARTS-1:0] r_tint;
  logic [63:0]       r_rdata;
  logic              r_err;
  logic [63:0]       w_off;
  logic [63:0]       w_mask;
  logic [63:0]       w_rsel;
  logic [4:0]        w_slot;
  logic              w_is_time;
  logic              w_is_cmp;
  logic              w_is_sip;
  logic              w_err;
  logic              w_wr;
  assign w_off     = (mmio_addr & MMIO_BASE_MASK) - (MMIO_BASE_ADDR & MMIO_BASE_MASK);
  assign w_slot    = w_off[7:3];
  assign w_is_time = w_off[63:3] == '0;
  // mtimecmp slots start at 0x008, so slot n maps to hart n-1
  assign w_is_cmp  = w_off[63:8] == '0 && w_slot != '0 && w_slot <= 5'(NHARTS);
  assign w_is_sip  = w_off[63:8] == 56'd1 && w_slot < 5'(NHARTS);
  assign w_err     = !(w_is_time || w_is_cmp || w_is_sip) || |mmio_addr[2:0] || |w_off[2:0];
  assign w_wr      = mmio_req && mmio_wen && !w_err;
  always_comb begin
    w_mask = '0;
    for (int k = 0; k < 8; k++) w_mask[8*k +: 8] = {8{mmio_strb[k]}};
  end
  always_comb begin
    w_rsel = w_is_time ? r_mtime : '0;
    for (int i = 0; i < NHARTS; i++) begin
      w_rsel = (w_is_cmp && w_slot == 5'(i + 1)) ? r_cmp[i] : w_rsel;
      w_rsel = (w_is_sip && w_slot == 5'(i)) ? {63'd0, r_msip[i]} : w_rsel;
    end
  end
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      r_mtime <= '0;
      r_pre   <= '0;
      r_msip  <= '0;
      r_tint  <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      for (int i = 0; i < NHARTS; i++) r_cmp[i] <= MTIMECMP_RESET;
    end else begin
      // a software write to mtime suppresses that cycle's tick
      if (w_wr && w_is_time) begin
        r_mtime <= (r_mtime & ~w_mask) | (mmio_wdata & w_mask);
        r_pre   <= '0;
      end else if (!inhibit_tm) begin
        r_mtime <= (r_pre == PMAX) ? r_mtime + 64'd1 : r_mtime;
        r_pre   <= (r_pre == PMAX) ? '0 : r_pre + PW'(1);
      end
      for (int i = 0; i < NHARTS; i++) begin
        if (w_wr && w_is_cmp && w_slot == 5'(i + 1))
          r_cmp[i] <= (r_cmp[i] & ~w_mask) | (mmio_wdata & w_mask);
        if (w_wr && w_is_sip && w_slot == 5'(i) && mmio_strb[0])
          r_msip[i] <= mmio_wdata[0];
        r_tint[i] <= r_mtime >= r_cmp[i];
      end
      if (mmio_req) begin
        r_rdata <= w_err ? '0 : w_rsel;
        r_err   <= w_err;
      end
    end
  end
  assign mmio_gnt        = 1'b1;
  assign mmio_rdata      = r_rdata;
  assign mmio_error      = r_err;
  assign ctr_time        = r_mtime;
  assign timer_interrupt = r_tint;
  assign soft_interrupt  = r_msip;
endmodule

// File: tb/tb_core_clint.sv
// tb_core_clint: random and directed checks of core_clint against a register-map model.
module tb_core_clint;
  localparam int N = 2;
  localparam logic [63:0] BASE = 64'h1000;
  localparam logic [63:0] MASK = 64'h1FFF;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic resetn, inh, req, wen;
  logic [7:0] strb;
  logic [63:0] addr, wdata;
  logic gnt, err, gnt3, err3;
  logic [63:0] rdata, tm, rdata3, tm3;
  logic [N-1:0] tint, sint, tint3, sint3;
  int errors = 0;
  int checks = 0;
  logic [63:0] m_time, m_rdata;
  logic m_err;
  logic [63:0] m_cmp [N];
  logic [N-1:0] m_msip, m_tint;
  core_clint dut (
    .g_clk(clk), .g_resetn(resetn), .inhibit_tm(inh), .mmio_req(req), .mmio_wen(wen),
    .mmio_strb(strb), .mmio_addr(addr), .mmio_wdata(wdata), .mmio_gnt(gnt),
    .mmio_rdata(rdata), .mmio_error(err), .ctr_time(tm), .timer_interrupt(tint),
    .soft_interrupt(sint)
  );
  core_clint #(.TICK_DIV(3)) dut3 (
    .g_clk(clk), .g_resetn(resetn), .inhibit_tm(inh), .mmio_req(req), .mmio_wen(wen),
    .mmio_strb(strb), .mmio_addr(addr), .mmio_wdata(wdata), .mmio_gnt(gnt3),
    .mmio_rdata(rdata3), .mmio_error(err3), .ctr_time(tm3), .timer_interrupt(tint3),
    .soft_interrupt(sint3)
  );
  function automatic logic [63:0] merge(input logic [63:0] v);
    for (int k = 0; k < 8; k++) if (strb[k]) v[8*k +: 8] = wdata[8*k +: 8];
    return v;
  endfunction
  // advance the register-map model by one clock using the current inputs, then clock the DUTs
  task automatic tick();
    logic [63:0] off, rv;
    logic e, tw;
    logic [N-1:0] nt;
    int h;
    if (!resetn) begin
      m_time = '0; m_rdata = '0; m_err = 1'b0; m_msip = '0; m_tint = '0;
      for (int i = 0; i < N; i++) m_cmp[i] = '1;
    end else begin
      for (int i = 0; i < N; i++) nt[i] = m_time >= m_cmp[i];
      off = (addr & MASK) - (BASE & MASK);
      e = 1'b1; rv = '0; tw = 1'b0;
      if (addr[2:0] == 3'd0) begin
        if (off == 64'd0) begin
          e = 1'b0; rv = m_time;
          if (req && wen) begin m_time = merge(m_time); tw = 1'b1; end
        end else if (off >= 64'd8 && off < 64'(8 + 8 * N)) begin
          h = int'((off - 64'd8) / 64'd8); e = 1'b0; rv = m_cmp[h];
          if (req && wen) m_cmp[h] = merge(m_cmp[h]);
        end else if (off >= 64'd256 && off < 64'(256 + 8 * N)) begin
          h = int'((off - 64'd256) / 64'd8); e = 1'b0; rv = {63'd0, m_msip[h]};
          if (req && wen && strb[0]) m_msip[h] = wdata[0];
        end
      end
      if (!tw && !inh) m_time = m_time + 64'd1;
      if (req) begin m_rdata = e ? '0 : rv; m_err = e; end
      m_tint = nt;
    end
    @(posedge clk); #1;
  endtask
  task automatic access(input logic w, input logic [63:0] o, input logic [63:0] d, input logic [7:0] s);
    req = 1'b1; wen = w; addr = BASE + o; wdata = d; strb = s;
    tick();
    req = 1'b0; wen = 1'b0;
  endtask
  task automatic test_reset();
    int exp_t [7] = '{0, 0, 0, 1, 1, 1, 2};
    resetn = 1'b0; inh = 1'b0; req = 1'b0; wen = 1'b0; strb = '0; addr = '0; wdata = '0;
    tick(); tick();
    checks++; if (rdata !== 64'd0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_error: got %b want 0", err); end
    checks++; if (tm !== 64'd0) begin errors++; $display("FAIL reset_time: got %h want 0", tm); end
    checks++; if (tint !== 2'b00 || sint !== 2'b00) begin errors++; $display("FAIL reset_irq: got tint=%b sint=%b want 00", tint, sint); end
    checks++; if (tm3 !== 64'd0) begin errors++; $display("FAIL reset_time3: got %h want 0", tm3); end
    checks++; if (gnt !== 1'b1) begin errors++; $display("FAIL gnt: got %b want 1", gnt); end
    resetn = 1'b1;
    for (int c = 1; c < 7; c++) begin
      tick();
      checks++; if (tm3 !== 64'(exp_t[c])) begin errors++; $display("FAIL prescale_c%0d: got %0d want %0d", c, tm3, exp_t[c]); end
    end
    checks++; if (tint3 !== 2'b00 || sint3 !== 2'b00) begin errors++; $display("FAIL prescale_irq: got tint=%b sint=%b want 00", tint3, sint3); end
    checks++; if (tm !== 64'd6) begin errors++; $display("FAIL div1_time: got %0d want 6", tm); end
  endtask
  task automatic test_timer();
    access(1'b1, 64'h10, 64'd10, 8'hFF);
    access(1'b1, 64'h0, 64'd8, 8'hFF);
    checks++; if (tm !== 64'd8) begin errors++; $display("FAIL timer_load: got %0d want 8", tm); end
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++; if (tint[1] !== (i >= 2)) begin errors++; $display("FAIL timer_rise_%0d: got %b want %b (time=%0d)", i, tint[1], i >= 2, tm); end
      checks++; if (tint[0] !== 1'b0) begin errors++; $display("FAIL timer_ch0_%0d: got %b want 0", i, tint[0]); end
      checks++; if (tm !== m_time) begin errors++; $display("FAIL timer_time_%0d: got %0d want %0d", i, tm, m_time); end
    end
  endtask
  task automatic test_strobe();
    inh = 1'b1;
    access(1'b1, 64'h0, 64'h1234_5678_9ABC_DEF0, 8'hFF);
    access(1'b1, 64'h0, '1, 8'h0F);
    tick();
    checks++; if (tm !== 64'h1234_5678_FFFF_FFFF) begin errors++; $display("FAIL strobe_low: got %h want 12345678ffffffff", tm); end
    access(1'b1, 64'h0, 64'd0, 8'h00);
    tick();
    checks++; if (tm !== 64'h1234_5678_FFFF_FFFF) begin errors++; $display("FAIL strobe_zero: got %h want 12345678ffffffff", tm); end
    access(1'b1, 64'h0, 64'hAA00_0000_0000_0000, 8'h80);
    checks++; if (tm !== 64'hAA34_5678_FFFF_FFFF || tm !== m_time) begin errors++; $display("FAIL strobe_high: got %h want aa345678ffffffff", tm); end
  endtask
  task automatic test_wrap();
    inh = 1'b1;
    access(1'b1, 64'h8, 64'd5, 8'hFF);
    inh = 1'b0;
    access(1'b1, 64'h0, '1, 8'hFF);
    checks++; if (tm !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL wrap_load: got %h want all ones", tm); end
    tick();
    checks++; if (tm !== 64'd0) begin errors++; $display("FAIL wrap_zero: got %h want 0", tm); end
    checks++; if (tint[0] !== 1'b1) begin errors++; $display("FAIL wrap_tint_hold: got %b want 1", tint[0]); end
    tick();
    checks++; if (tint[0] !== 1'b0) begin errors++; $display("FAIL wrap_tint_fall: got %b want 0", tint[0]); end
    checks++; if (tint !== m_tint) begin errors++; $display("FAIL wrap_tint: got %b want %b", tint, m_tint); end
  endtask
  task automatic test_soft();
    access(1'b1, 64'h108, 64'd1, 8'h01);
    checks++; if (sint !== 2'b10) begin errors++; $display("FAIL soft_set: got %b want 10", sint); end
    access(1'b0, 64'h108, 64'd0, 8'h00);
    checks++; if (rdata !== 64'd1 || err !== 1'b0) begin errors++; $display("FAIL soft_read: got %h err=%b want 1 err=0", rdata, err); end
    access(1'b0, 64'h4, 64'd0, 8'h00);
    checks++; if (err !== 1'b1 || rdata !== 64'd0) begin errors++; $display("FAIL misalign: got err=%b rdata=%h want err=1 rdata=0", err, rdata); end
    access(1'b1, 64'h18, 64'd0, 8'hFF);
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL bad_hart: got err=%b want 1", err); end
    access(1'b0, 64'h10, 64'd0, 8'h00);
    checks++; if (rdata !== 64'd10 || err !== 1'b0) begin errors++; $display("FAIL cmp1_kept: got %h want 10", rdata); end
    access(1'b0, 64'h8, 64'd0, 8'h00);
    checks++; if (rdata !== 64'd5) begin errors++; $display("FAIL cmp0_kept: got %h want 5", rdata); end
    access(1'b0, 64'h200, 64'd0, 8'h00);
    checks++; if (err !== 1'b1 || rdata !== 64'd0) begin errors++; $display("FAIL unmapped: got err=%b rdata=%h want 1/0", err, rdata); end
    tick();
    checks++; if (err !== 1'b1 || rdata !== 64'd0) begin errors++; $display("FAIL idle_hold: got err=%b rdata=%h want 1/0", err, rdata); end
  endtask
  task automatic test_random();
    logic [63:0] offs [10] = '{64'h0, 64'h4, 64'h8, 64'h10, 64'h18, 64'h100, 64'h108, 64'h110, 64'h2008, 64'h20};
    for (int c = 0; c < 400; c++) begin
      resetn = $urandom_range(0, 63) != 0;
      inh = $urandom_range(0, 3) == 0;
      req = $urandom_range(0, 1) == 1;
      wen = $urandom_range(0, 1) == 1;
      strb = 8'($urandom);
      addr = BASE + offs[$urandom_range(0, 9)];
      wdata = $urandom_range(0, 1) == 1 ? {$urandom, $urandom} : 64'($urandom_range(0, 40));
      tick();
      checks++; if (rdata !== m_rdata) begin errors++; $display("FAIL rnd_rdata_%0d: got %h want %h", c, rdata, m_rdata); end
      checks++; if (err !== m_err) begin errors++; $display("FAIL rnd_error_%0d: got %b want %b", c, err, m_err); end
      checks++; if (tm !== m_time) begin errors++; $display("FAIL rnd_time_%0d: got %h want %h", c, tm, m_time); end
      checks++; if (tint !== m_tint) begin errors++; $display("FAIL rnd_tint_%0d: got %b want %b", c, tint, m_tint); end
      checks++; if (sint !== m_msip) begin errors++; $display("FAIL rnd_sint_%0d: got %b want %b", c, sint, m_msip); end
    end
    req = 1'b0; wen = 1'b0; resetn = 1'b1; inh = 1'b0;
  endtask
  task automatic test_reset_mid();
    resetn = 1'b1; inh = 1'b0;
    access(1'b1, 64'h108, 64'd1, 8'h01);
    access(1'b0, 64'h0, 64'd0, 8'h00);
    checks++; if (rdata !== m_rdata) begin errors++; $display("FAIL mid_read: got %h want %h", rdata, m_rdata); end
    req = 1'b1; addr = BASE; resetn = 1'b0;
    tick();
    req = 1'b0; resetn = 1'b1;
    checks++; if (rdata !== 64'd0 || err !== 1'b0) begin errors++; $display("FAIL mid_discard: got %h err=%b want 0/0", rdata, err); end
    checks++; if (tm !== 64'd0 || tint !== 2'b00 || sint !== 2'b00) begin errors++; $display("FAIL mid_state: got time=%h tint=%b sint=%b want 0", tm, tint, sint); end
    tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    checks++; if (tm3 !== 64'd0) begin errors++; $display("FAIL mid_time3: got %h want 0", tm3); end
    tick(); tick();
    checks++; if (tm3 !== 64'd0) begin errors++; $display("FAIL mid_pre_cleared: got %0d want 0", tm3); end
    tick();
    checks++; if (tm3 !== 64'd1) begin errors++; $display("FAIL mid_pre_tick: got %0d want 1", tm3); end
  endtask
  initial begin
    test_reset();
    test_timer();
    test_strobe();
    test_wrap();
    test_soft();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
